wir_serial_loader: RTL and testbench
====================================

Name: wir_serial_loader

Overview:
- Upstream sequencer for the IEEE 1500 Wrapper Instruction Register (WIR). It accepts a parallel instruction word with a start pulse and drives the WIR's serial input and its SelectWIR/CaptureWR/ShiftWR/UpdateWR controls through an optional capture, a shift and an update.
- While shifting, it collects the WIR serial output, so the previously loaded instruction can be read back.
- It replaces the ad-hoc parallel-to-serial shifter and hand-timed control waveforms previously used to drive the WIR.

Parameters:
- INSTR_W, 12, WIR length in bits; number of shift cycles per load.
- CNT_W, $clog2(INSTR_W+1), width of the shift counter (derived, not overridden).

Ports:
- WRCK  input  1  wrapper clock; all state updates on rising edge.
- resetn  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- instr  input  INSTR_W  instruction to load; latched when start is accepted.
- capture_en  input  1  when 1, a CAPTURE cycle precedes the shift; latched with start.
- wir_so  input  1  serial output of the WIR.
- wsi  output  1  serial data to the WIR.
- SelectWIR  output  1  WIR select.
- CaptureWR  output  1  capture strobe.
- ShiftWR  output  1  shift enable.
- UpdateWR  output  1  update strobe.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- readback  output  INSTR_W  wir_so bits collected during the last shift, LSB = first bit.

Behaviour:
- All outputs are registered.
- Reset values: every output is 0, readback is 0, state is IDLE.
- Reset assertion during any operation forces reset values immediately (asynchronous), with no update pulse. After release the block is in IDLE.
- FSM states: IDLE, CAPTURE, SHIFT, UPDATE, DONE.
- IDLE:
  - start=1 latches instr into shreg and latches capture_en, and sets the counter to 0.
  - Next state is CAPTURE if capture_en=1, otherwise SHIFT.
  - start while busy is ignored, not queued.
- CAPTURE (1 cycle): SelectWIR=1, CaptureWR=1. Next state is SHIFT.
- SHIFT (exactly INSTR_W cycles):
  - SelectWIR=1, ShiftWR=1, wsi=shreg[0].
  - On each edge: shreg shifts right; wir_so is shifted into the readback register at the MSB (right-shift), so that after INSTR_W cycles the first bit is at readback[0]; the counter increments.
  - Leaves SHIFT when the counter reaches INSTR_W-1.
  - The bits go out LSB first, so instr[0] is the first bit on wsi.
- UPDATE (1 cycle): SelectWIR=1, UpdateWR=1, ShiftWR=0. Next state is DONE.
- DONE (1 cycle): done=1, SelectWIR=0, busy=1. Next state is IDLE, where done and busy return to 0.
- Mutual exclusion: CaptureWR, ShiftWR and UpdateWR are never high in the same cycle.
- SelectWIR is high continuously from the first CAPTURE/SHIFT cycle through UPDATE, with no gap.
- Latency, counting the start-sampling edge as edge 0:
  - capture_en=1: CAPTURE is cycle 1, SHIFT is cycles 2..INSTR_W+1, UPDATE is INSTR_W+2, done is INSTR_W+3.
  - capture_en=0: every phase is one cycle earlier.
- readback:
  - Holds its value after DONE until the next SHIFT starts.
  - Updates on every shift, whether or not capture_en was set.
- instr and capture_en changing while busy have no effect.
- INSTR_W=1: SHIFT lasts one cycle and the counter is still legal.

Decomposition:
- Shared package wsp_pkg holds:
  - the state enum (IDLE, CAPTURE, SHIFT, UPDATE, DONE);
  - default WIR length constant WIR_LEN=12;
  - instruction opcode constants used by the WIR decoder.
- Single module; no sub-module needed. The shift/readback register pair may be a local always block.

Test Plan:
1. Load with capture: reset, then start with instr=12'b010010010010, capture_en=1.
   - CaptureWR high for exactly 1 cycle at cycle 1.
   - ShiftWR high for cycles 2..13; wsi sequence over cycles 2..13 is 0,1,0,0,1,0,0,1,0,0,1,0.
   - UpdateWR at cycle 14, done at cycle 15.
   - The WIR decode outputs match opcode 0x492.
2. Readback: first load 0x492, then load 0xFFF with capture_en=0.
   - readback equals the wir_so sequence observed, and the WIR shows 0xFFF after update.
3. Busy rejection: pulse start with 0x0A5 during SHIFT of a 0x492 load.
   - Load completes with 0x492; no second sequence starts; busy drops one cycle after done.
4. Reset mid-shift: deassert resetn at shift cycle 6.
   - All controls go 0 immediately, no UpdateWR pulse, and the WIR keeps its prior instruction.
   - After release a new start completes normally.
5. Back-to-back loads: assert start on the cycle right after done.
   - It is accepted, the second sequence timing is identical, and SelectWIR is low for at least one cycle between the two sequences.
6. Protocol assertions across random instr and capture_en for 200 loads:
   - CaptureWR, ShiftWR and UpdateWR are mutually exclusive.
   - ShiftWR is high for exactly 12 cycles per load.
   - done occurs exactly once per accepted start.

Source files
------------

// File: rtl/wir_serial_loader_pkg.sv
// -----------------------------------------------------------------------------
// wsp_pkg
// Shared definitions for the WIR serial loader and the logic around it.
//   - state_t  : loader sequencing states
//   - WIR_LEN  : default Wrapper Instruction Register length
//   - OPC_*    : instruction opcodes recognised by the WIR decoder
// -----------------------------------------------------------------------------
package wsp_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        SHIFT   = 3'd2,
        UPDATE  = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int WIR_LEN = 12;

    // WIR instruction opcodes (WIR_LEN bits wide)
    localparam logic [WIR_LEN-1:0] OPC_WS_BYPASS  = 12'h000;
    localparam logic [WIR_LEN-1:0] OPC_WS_EXTEST  = 12'h492;
    localparam logic [WIR_LEN-1:0] OPC_WS_INTEST  = 12'h0A5;
    localparam logic [WIR_LEN-1:0] OPC_WS_SAMPLE  = 12'h3C3;
    localparam logic [WIR_LEN-1:0] OPC_WS_PRELOAD = 12'hFFF;

endpackage

// File: rtl/wir_serial_loader_if.sv
// -----------------------------------------------------------------------------
// wir_serial_loader_if
// Serial/control bundle between the WIR loader and the Wrapper Instruction
// Register.
//   wsi        : serial data into the WIR
//   wir_so     : serial data out of the WIR
//   SelectWIR  : WIR select
//   CaptureWR  : capture strobe
//   ShiftWR    : shift enable
//   UpdateWR   : update strobe
// Modports: master = loader side, slave = WIR side.
// -----------------------------------------------------------------------------
interface wir_serial_loader_if;

    logic wsi;
    logic wir_so;
    logic SelectWIR;
    logic CaptureWR;
    logic ShiftWR;
    logic UpdateWR;

    modport master (
        output wsi,
        output SelectWIR,
        output CaptureWR,
        output ShiftWR,
        output UpdateWR,
        input  wir_so
    );

    modport slave (
        input  wsi,
        input  SelectWIR,
        input  CaptureWR,
        input  ShiftWR,
        input  UpdateWR,
        output wir_so
    );

endinterface

// File: rtl/wir_serial_loader.sv
// -----------------------------------------------------------------------------
// wir_serial_loader
// Sequences one load of the IEEE 1500 Wrapper Instruction Register: optional
// CAPTURE, INSTR_W SHIFT cycles (LSB first), UPDATE, then a one-cycle DONE.
// The bits shifted out of the WIR are collected into readback (first bit at
// readback[0]) so the previously loaded instruction can be inspected.
//
// Ports:
//   WRCK        in   wrapper clock, rising edge
//   resetn      in   asynchronous active-low reset
//   start       in   load request, honoured only when idle
//   instr       in   instruction to load, sampled with start
//   capture_en  in   insert a CAPTURE cycle before shifting, sampled with start
//   wir         if   master side of the WIR serial/control bundle
//   busy        out  high whenever not idle
//   done        out  one-cycle completion pulse
//   readback    out  WIR serial output collected during the last shift
//
// All outputs are registered: each output register is loaded from the value
// the output must have in the state being entered, so outputs and state
// change on the same edge.
// -----------------------------------------------------------------------------
module wir_serial_loader
    import wsp_pkg::*;
#(
    parameter  int INSTR_W = WIR_LEN,
    localparam int CNT_W   = $clog2(INSTR_W + 1)
) (
    input  logic                   WRCK,
    input  logic                   resetn,
    input  logic                   start,
    input  logic [INSTR_W-1:0]     instr,
    input  logic                   capture_en,
    wir_serial_loader_if.master    wir,
    output logic                   busy,
    output logic                   done,
    output logic [INSTR_W-1:0]     readback
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(INSTR_W - 1);

    state_t               state_reg, state_next;
    logic [INSTR_W-1:0]   shreg_reg, shreg_next;
    logic [INSTR_W-1:0]   readback_reg, readback_next;
    logic [INSTR_W-1:0]   readback_shifted;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;

    logic wsi_reg,      wsi_next;
    logic select_reg,   select_next;
    logic capture_reg,  capture_next;
    logic shift_reg,    shift_next;
    logic update_reg,   update_next;
    logic busy_reg,     busy_next;
    logic done_reg,     done_next;

    // Readback shifts right with wir_so entering at the MSB; after INSTR_W
    // shifts the first bit seen lands at bit 0. Built bitwise so that an
    // INSTR_W of 1 needs no special-cased slice.
    assign readback_shifted[INSTR_W-1] = wir.wir_so;
    generate
        for (genvar gi = 0; gi < INSTR_W - 1; gi++) begin : g_rb_shift
            assign readback_shifted[gi] = readback_reg[gi + 1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        shreg_next    = shreg_reg;
        readback_next = readback_reg;
        cnt_next      = cnt_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    shreg_next = instr;
                    cnt_next   = '0;
                    // capture_en only steers this one decision, so it is
                    // consumed at the accepting edge rather than held.
                    state_next = capture_en ? CAPTURE : SHIFT;
                end
            end
            CAPTURE: begin
                state_next = SHIFT;
            end
            SHIFT: begin
                shreg_next    = shreg_reg >> 1;
                readback_next = readback_shifted;
                cnt_next      = cnt_reg + 1'b1;
                if (cnt_reg == LAST_CNT) begin
                    state_next = UPDATE;
                end
            end
            UPDATE: begin
                state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode from the state being entered
    // ------------------------------------------------------------------
    always_comb begin
        wsi_next     = 1'b0;
        select_next  = 1'b0;
        capture_next = 1'b0;
        shift_next   = 1'b0;
        update_next  = 1'b0;
        busy_next    = (state_next != IDLE);
        done_next    = 1'b0;

        case (state_next)
            CAPTURE: begin
                select_next  = 1'b1;
                capture_next = 1'b1;
            end
            SHIFT: begin
                select_next = 1'b1;
                shift_next  = 1'b1;
                // shreg_next[0] is the bit the WIR will sample at the end
                // of this shift cycle.
                wsi_next    = shreg_next[0];
            end
            UPDATE: begin
                select_next = 1'b1;
                update_next = 1'b1;
            end
            DONE: begin
                done_next = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge WRCK or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= IDLE;
            shreg_reg    <= '0;
            readback_reg <= '0;
            cnt_reg      <= '0;
            wsi_reg      <= 1'b0;
            select_reg   <= 1'b0;
            capture_reg  <= 1'b0;
            shift_reg    <= 1'b0;
            update_reg   <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            shreg_reg    <= shreg_next;
            readback_reg <= readback_next;
            cnt_reg      <= cnt_next;
            wsi_reg      <= wsi_next;
            select_reg   <= select_next;
            capture_reg  <= capture_next;
            shift_reg    <= shift_next;
            update_reg   <= update_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    assign wir.wsi       = wsi_reg;
    assign wir.SelectWIR = select_reg;
    assign wir.CaptureWR = capture_reg;
    assign wir.ShiftWR   = shift_reg;
    assign wir.UpdateWR  = update_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;
    assign readback      = readback_reg;

endmodule

// File: tb/tb_wir_serial_loader.sv
// -----------------------------------------------------------------------------
// tb_wir_serial_loader
// Directed and random loads of wir_serial_loader against a behavioural WIR
// (shift register + update register). Expected load results are queued when
// a load is started and popped when done is seen.
// -----------------------------------------------------------------------------
module tb_wir_serial_loader;
    import wsp_pkg::*;

    localparam int W = WIR_LEN;

    logic          WRCK       = 1'b0;
    logic          resetn     = 1'b0;
    logic          start      = 1'b0;
    logic          capture_en = 1'b0;
    logic [W-1:0]  instr      = '0;
    logic          busy;
    logic          done;
    logic [W-1:0]  readback;

    wir_serial_loader_if wir ();

    wir_serial_loader #(.INSTR_W(W)) dut (
        .WRCK       (WRCK),
        .resetn     (resetn),
        .start      (start),
        .instr      (instr),
        .capture_en (capture_en),
        .wir        (wir),
        .busy       (busy),
        .done       (done),
        .readback   (readback)
    );

    always #5 WRCK = ~WRCK;

    // Behavioural WIR: not affected by the loader reset.
    logic [W-1:0] wir_sr = '0;
    logic [W-1:0] wir_ur = '0;
    assign wir.wir_so = wir_sr[0];

    always @(posedge WRCK) begin
        if (wir.CaptureWR)
            wir_sr <= wir_ur;
        else if (wir.ShiftWR)
            wir_sr <= {wir.wsi, wir_sr[W-1:1]};
        if (wir.UpdateWR)
            wir_ur <= wir_sr;
    end

    typedef struct {
        logic [W-1:0] instr;
        logic [W-1:0] rb;
    } exp_t;

    exp_t         sb[$];
    int           n_cmp = 0;
    int           n_err = 0;
    logic [W-1:0] last_loaded = '0;

    function automatic int decode(input logic [W-1:0] ur);
        case (ur)
            OPC_WS_BYPASS:  return 0;
            OPC_WS_EXTEST:  return 1;
            OPC_WS_INTEST:  return 2;
            OPC_WS_SAMPLE:  return 3;
            OPC_WS_PRELOAD: return 4;
            default:        return 5;
        endcase
    endfunction

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_v(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs == exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge WRCK);
    endtask

    task automatic chk_idle(input string tag);
        chk_b({tag, "_busy"}, busy, 1'b0);
        chk_b({tag, "_done"}, done, 1'b0);
        chk_b({tag, "_sel"},  wir.SelectWIR, 1'b0);
        chk_b({tag, "_shift"}, wir.ShiftWR, 1'b0);
    endtask

    // One load starting at the current negedge. Cycle k is the period after
    // the k-th rising edge counted from the start-sampling edge (edge 0).
    // inj_k : cycle in which a stray start (INTEST) is pulsed, -1 = none
    // rst_k : cycle in which resetn is pulled low mid-cycle, -1 = none
    task automatic do_load(input logic [W-1:0] v, input logic cap,
                           input int inj_k, input int rst_k, input bit noise);
        int           c;
        int           shifts;
        int           dones;
        int           sum;
        logic [W-1:0] so_seen;
        exp_t         e;
        c       = cap ? 1 : 0;
        shifts  = 0;
        dones   = 0;
        so_seen = '0;

        instr      = v;
        capture_en = cap;
        start      = 1'b1;
        e.instr    = v;
        e.rb       = last_loaded;
        sb.push_back(e);
        step();
        start = 1'b0;

        for (int k = 1; k <= W + 2 + c; k++) begin
            logic e_sh;
            logic e_wsi;
            e_sh  = (k >= 1 + c) && (k <= W + c);
            e_wsi = e_sh ? v[k - 1 - c] : 1'b0;

            chk_b($sformatf("cap@%0d", k),  wir.CaptureWR, (c == 1) && (k == 1));
            chk_b($sformatf("shift@%0d", k), wir.ShiftWR, e_sh);
            chk_b($sformatf("wsi@%0d", k),  wir.wsi, e_wsi);
            chk_b($sformatf("upd@%0d", k),  wir.UpdateWR, k == W + 1 + c);
            chk_b($sformatf("done@%0d", k), done, k == W + 2 + c);
            chk_b($sformatf("sel@%0d", k),  wir.SelectWIR, k <= W + 1 + c);
            chk_b($sformatf("busy@%0d", k), busy, 1'b1);
            sum = int'(wir.CaptureWR) + int'(wir.ShiftWR) + int'(wir.UpdateWR);
            chk_b($sformatf("mutex@%0d", k), sum <= 1, 1'b1);

            if (wir.ShiftWR) begin
                so_seen = {wir.wir_so, so_seen[W-1:1]};
                shifts++;
            end

            if (done) begin
                dones++;
                chk_b("sb_nonempty", sb.size() > 0, 1'b1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk_v("readback", readback, e.rb);
                    chk_v("readback_so", readback, so_seen);
                    chk_v("wir_update", wir_ur, e.instr);
                    $display("load instr=%h cap=%0d readback=%h wir=%h", v, c, readback, wir_ur);
                end
                last_loaded = v;
            end

            if (k == rst_k) begin
                #2 resetn = 1'b0;
                #1;
                chk_b("rst_sel",   wir.SelectWIR, 1'b0);
                chk_b("rst_shift", wir.ShiftWR, 1'b0);
                chk_b("rst_wsi",   wir.wsi, 1'b0);
                chk_b("rst_upd",   wir.UpdateWR, 1'b0);
                chk_b("rst_busy",  busy, 1'b0);
                chk_v("rst_rb",    readback, '0);
                void'(sb.pop_back());
                for (int r = 0; r < 2; r++) begin
                    step();
                    chk_b("rst_hold_upd", wir.UpdateWR, 1'b0);
                    chk_b("rst_hold_busy", busy, 1'b0);
                end
                chk_v("rst_wir_kept", wir_ur, last_loaded);
                resetn = 1'b1;
                step();
                chk_idle("post_rst");
                $display("load instr=%h aborted by reset at cycle %0d", v, k);
                return;
            end

            if (k == inj_k) begin
                start = 1'b1;
                instr = OPC_WS_INTEST;
            end else begin
                start = 1'b0;
            end
            if (noise) begin
                instr      = W'($urandom);
                capture_en = 1'($urandom);
            end
            step();
        end

        start = 1'b0;
        chk_idle("after_done");
        chk_i("shift_cycles", shifts, W);
        chk_i("done_count", dones, 1);
    endtask

    initial begin
        // Reset state
        resetn = 1'b0;
        step();
        step();
        chk_idle("reset");
        chk_b("reset_wsi", wir.wsi, 1'b0);
        chk_b("reset_upd", wir.UpdateWR, 1'b0);
        chk_b("reset_cap", wir.CaptureWR, 1'b0);
        chk_v("reset_rb", readback, '0);
        resetn = 1'b1;
        step();
        chk_idle("released");

        // 1: load with capture, decode check
        do_load(OPC_WS_EXTEST, 1'b1, -1, -1, 1'b0);
        chk_i("decode_extest", decode(wir_ur), 1);

        // 2: readback of previous instruction, then a no-capture load
        do_load(OPC_WS_PRELOAD, 1'b0, -1, -1, 1'b0);
        chk_v("wir_fff", wir_ur, OPC_WS_PRELOAD);

        // 3: stray start during SHIFT is ignored
        do_load(OPC_WS_EXTEST, 1'b1, 5, -1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk_idle("no_second");
            step();
        end
        chk_v("wir_after_reject", wir_ur, OPC_WS_EXTEST);

        // 4: reset at the 6th shift cycle, then a normal load
        do_load(OPC_WS_SAMPLE, 1'b1, -1, 7, 1'b0);
        chk_v("wir_after_abort", wir_ur, OPC_WS_EXTEST);
        do_load(OPC_WS_INTEST, 1'b1, -1, -1, 1'b0);

        // 5: back-to-back loads (each call starts in the idle cycle after done)
        do_load(OPC_WS_SAMPLE, 1'b0, -1, -1, 1'b0);
        do_load(OPC_WS_BYPASS, 1'b1, -1, -1, 1'b0);
        do_load(OPC_WS_EXTEST, 1'b0, -1, -1, 1'b0);

        // 6: random loads
        for (int i = 0; i < 200; i++) begin
            do_load(W'($urandom), 1'($urandom), -1, -1, 1'b1);
        end

        chk_i("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
